// File: rtl/debounce_array_arbiter.sv
// debounce_array_arbiter: shared-prescaler switch debouncer with per-channel event slots
// drained round-robin into a single valid/ready event stream.
module debounce_array_arbiter #(
    parameter int NumCh         = 4,
    parameter int ClkFreq       = 100_000_000,
    parameter int SampleUs      = 1000,
    parameter int StableSamples = 10,
    localparam int ChW          = NumCh > 1 ? $clog2(NumCh) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumCh-1:0] sw_i,
    output logic [NumCh-1:0] db_level_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [ChW-1:0]   evt_ch_o,
    output logic             evt_rise_o,
    output logic             evt_overflow_o
);
    localparam int SampleDiv = (ClkFreq / 1_000_000) * SampleUs;
    localparam int PW        = $clog2(SampleDiv);
    localparam int CW        = StableSamples > 1 ? $clog2(StableSamples) : 1;

    logic [PW-1:0]    pcnt;
    logic             tick;
    logic [NumCh-1:0] meta, sync, evt_wr, slot_v, slot_r, gnt_vec;
    logic [CW-1:0]    cnt [NumCh];
    logic [ChW-1:0]   ptr, gnt_idx, nxt_ptr;
    logic             any_v, out_free, load;

    assign tick     = pcnt == PW'(SampleDiv - 1);
    assign any_v    = |slot_v;
    assign out_free = !evt_valid_o || evt_ready_i;
    assign load     = out_free && any_v;
    assign gnt_vec  = load ? (NumCh'(1) << gnt_idx) : '0;
    assign nxt_ptr  = gnt_idx == ChW'(NumCh - 1) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        evt_wr = '0;
        for (int i = 0; i < NumCh; i++)
            evt_wr[i] = tick && sync[i] != db_level_o[i] && cnt[i] == CW'(StableSamples - 1);
    end

    // Second pass overrides the first, so the lowest valid index at or above ptr wins before wrapping.
    always_comb begin
        gnt_idx = '0;
        for (int i = NumCh - 1; i >= 0; i--)
            if (slot_v[i] && i < int'(ptr)) gnt_idx = ChW'(i);
        for (int i = NumCh - 1; i >= 0; i--)
            if (slot_v[i] && i >= int'(ptr)) gnt_idx = ChW'(i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt           <= '0;
            meta           <= '0;
            sync           <= '0;
            db_level_o     <= '0;
            slot_v         <= '0;
            slot_r         <= '0;
            ptr            <= '0;
            evt_valid_o    <= 1'b0;
            evt_ch_o       <= '0;
            evt_rise_o     <= 1'b0;
            evt_overflow_o <= 1'b0;
            for (int i = 0; i < NumCh; i++) cnt[i] <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            meta <= sw_i;
            sync <= meta;
            for (int i = 0; i < NumCh; i++) begin
                if (tick) cnt[i] <= (sync[i] == db_level_o[i] || evt_wr[i]) ? '0 : cnt[i] + 1'b1;
                if (evt_wr[i]) db_level_o[i] <= sync[i];
            end
            // A fresh event always lands in its slot, even on the edge the old one is granted.
            slot_v         <= evt_wr | (slot_v & ~gnt_vec);
            slot_r         <= (evt_wr & sync) | (~evt_wr & slot_r);
            evt_overflow_o <= |(evt_wr & slot_v & ~gnt_vec);
            if (out_free) evt_valid_o <= any_v;
            if (load) begin
                evt_ch_o   <= gnt_idx;
                evt_rise_o <= slot_r[gnt_idx];
                ptr        <= nxt_ptr;
            end
        end
    end
endmodule

// File: tb/tb_debounce_array_arbiter.sv
// tb_debounce_array_arbiter: directed scenarios with a queue scoreboard checked by an
// independent monitor on every accepted event transfer.
module tb_debounce_array_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = '0;
    logic       evt_ready = 1'b1;
    logic [3:0] db_level;
    logic       evt_valid, evt_rise, evt_ovf;
    logic [1:0] evt_ch;

    int checks = 0;
    int failures = 0;
    int ovf_total = 0;
    int cyc = 0;
    int c0, c1;
    logic [2:0] exp_q [$];

    debounce_array_arbiter #(
        .NumCh(4), .ClkFreq(1_000_000), .SampleUs(4), .StableSamples(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sw_i(sw), .db_level_o(db_level),
        .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_ch_o(evt_ch),
        .evt_rise_o(evt_rise), .evt_overflow_o(evt_ovf)
    );

    always #5 clk = ~clk;

    // Edges since reset release; prescaler ticks on edges where cyc % 4 == 0.
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc=%0d)", name, got, exp, cyc);
        end
    endtask

    task automatic align();
        while (cyc % 4 != 0) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (evt_ovf) ovf_total++;
                if (evt_valid && evt_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_evt got ch=%0d rise=%0b exp=none", evt_ch, evt_rise);
                    end else chk("evt_payload", {29'd0, evt_ch, evt_rise}, {29'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_db", {28'd0, db_level}, 0);
        chk("rst_valid", {31'd0, evt_valid}, 0);
        chk("rst_ch", {30'd0, evt_ch}, 0);
        chk("rst_rise", {31'd0, evt_rise}, 0);
        chk("rst_ovf", {31'd0, evt_ovf}, 0);
        rst = 1'b0;
        // Round-robin under backpressure: 0,1,3 rise together.
        align();
        c0 = cyc;
        evt_ready = 1'b0;
        sw = 4'b1011;
        exp_q.push_back({2'd0, 1'b1});
        exp_q.push_back({2'd1, 1'b1});
        exp_q.push_back({2'd3, 1'b1});
        wait_until(c0 + 11);
        chk("rr_db_early", {28'd0, db_level}, 0);
        wait_until(c0 + 12);
        chk("rr_db", {28'd0, db_level}, 4'b1011);
        chk("rr_valid_lat0", {31'd0, evt_valid}, 0);
        wait_until(c0 + 13);
        chk("rr_head", {29'd0, evt_valid, evt_ch}, {29'd0, 1'b1, 2'd0});
        wait_until(c0 + 16);
        chk("rr_hold", {29'd0, evt_valid, evt_ch}, {29'd0, 1'b1, 2'd0});
        evt_ready = 1'b1;
        wait_until(c0 + 17);
        chk("rr_2nd", {29'd0, evt_valid, evt_ch}, {29'd0, 1'b1, 2'd1});
        wait_until(c0 + 18);
        chk("rr_3rd", {29'd0, evt_valid, evt_ch}, {29'd0, 1'b1, 2'd3});
        wait_until(c0 + 19);
        chk("rr_drained", {31'd0, evt_valid}, 0);
        // Simultaneous falls on 0 and 1 after pointer wrapped past 3.
        align();
        c0 = cyc;
        sw = 4'b1000;
        exp_q.push_back({2'd0, 1'b0});
        exp_q.push_back({2'd1, 1'b0});
        wait_until(c0 + 13);
        chk("wrap_first", {29'd0, evt_valid, evt_ch}, {29'd0, 1'b1, 2'd0});
        wait_until(c0 + 14);
        chk("wrap_second", {29'd0, evt_valid, evt_ch}, {29'd0, 1'b1, 2'd1});
        // Clean press on channel 2.
        align();
        c0 = cyc;
        sw[2] = 1'b1;
        exp_q.push_back({2'd2, 1'b1});
        wait_until(c0 + 11);
        chk("press_db_early", {31'd0, db_level[2]}, 0);
        wait_until(c0 + 12);
        chk("press_db", {31'd0, db_level[2]}, 1);
        chk("press_valid_lat0", {31'd0, evt_valid}, 0);
        wait_until(c0 + 13);
        chk("press_evt", {28'd0, evt_valid, evt_ch, evt_rise}, {28'd0, 1'b1, 2'd2, 1'b1});
        wait_until(c0 + 14);
        chk("press_one_cycle", {31'd0, evt_valid}, 0);
        // Bounce on channel 1: two high ticks, one low tick, then steady high.
        align();
        c0 = cyc;
        sw[1] = 1'b1;
        wait_until(c0 + 8);
        sw[1] = 1'b0;
        wait_until(c0 + 12);
        sw[1] = 1'b1;
        exp_q.push_back({2'd1, 1'b1});
        wait_until(c0 + 13);
        chk("bounce_no_db", {31'd0, db_level[1]}, 0);
        chk("bounce_no_evt", {31'd0, evt_valid}, 0);
        wait_until(c0 + 23);
        chk("bounce_db_early", {31'd0, db_level[1]}, 0);
        wait_until(c0 + 24);
        chk("bounce_db", {31'd0, db_level[1]}, 1);
        wait_until(c0 + 25);
        chk("bounce_evt", {28'd0, evt_valid, evt_ch, evt_rise}, {28'd0, 1'b1, 2'd1, 1'b1});
        // Overflow: output busy with ch3, ch0 rises then falls while its slot is pending.
        align();
        c0 = cyc;
        evt_ready = 1'b0;
        sw[3] = 1'b0;
        exp_q.push_back({2'd3, 1'b0});
        wait_until(c0 + 13);
        chk("ovf_busy", {28'd0, evt_valid, evt_ch, evt_rise}, {28'd0, 1'b1, 2'd3, 1'b0});
        c1 = c0 + 16;
        wait_until(c1);
        sw[0] = 1'b1;
        wait_until(c1 + 12);
        chk("ovf_db_rise", {31'd0, db_level[0]}, 1);
        sw[0] = 1'b0;
        exp_q.push_back({2'd0, 1'b0});
        wait_until(c1 + 23);
        chk("ovf_pre", {31'd0, evt_ovf}, 0);
        wait_until(c1 + 24);
        chk("ovf_pulse", {31'd0, evt_ovf}, 1);
        chk("ovf_hold", {28'd0, evt_valid, evt_ch, evt_rise}, {28'd0, 1'b1, 2'd3, 1'b0});
        wait_until(c1 + 25);
        chk("ovf_post", {31'd0, evt_ovf}, 0);
        evt_ready = 1'b1;
        wait_until(c1 + 26);
        chk("ovf_fall_only", {28'd0, evt_valid, evt_ch, evt_rise}, {28'd0, 1'b1, 2'd0, 1'b0});
        wait_until(c1 + 27);
        chk("ovf_drained", {31'd0, evt_valid}, 0);
        // Async reset with an event in flight, one pending and ch3 mid-count.
        align();
        c0 = cyc;
        evt_ready = 1'b0;
        sw = 4'b0000;
        wait_until(c0 + 12);
        sw[3] = 1'b1;
        wait_until(c0 + 18);
        chk("ar_pre_valid", {31'd0, evt_valid}, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_db", {28'd0, db_level}, 0);
        chk("ar_valid", {31'd0, evt_valid}, 0);
        chk("ar_ch", {30'd0, evt_ch}, 0);
        chk("ar_rise", {31'd0, evt_rise}, 0);
        chk("ar_ovf", {31'd0, evt_ovf}, 0);
        evt_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({2'd3, 1'b1});
        wait_until(11);
        chk("ar_db_early", {28'd0, db_level}, 0);
        wait_until(12);
        chk("ar_db_rise", {28'd0, db_level}, 4'b1000);
        wait_until(13);
        chk("ar_evt", {28'd0, evt_valid, evt_ch, evt_rise}, {28'd0, 1'b1, 2'd3, 1'b1});
        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("ovf_total", ovf_total, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
